wb_grf: RTL and testbench

WB_GRF -- requirements
Module: wb_grf

---
 rtl/wb_grf_if.sv | 29 ++
 rtl/wb_grf.sv | 94 +++++++++
 tb/tb_wb_grf.sv | 188 ++++++++++++++++++
 3 files changed

// File: rtl/wb_grf_if.sv
// Writeback/register-file bus: W-stage write controls, D-stage read ports,
// and the selected write address/data/strobe exported for forwarding.
interface wb_grf_if;
  logic [31:0] IR_W;
  logic [31:0] PC_W;
  logic [31:0] ALUout_W;
  logic [31:0] DMout_W;
  logic [1:0]  Wreg_sel;
  logic [1:0]  Wdata_sel;
  logic        GRF_WE;
  logic [4:0]  A1;
  logic [4:0]  A2;
  logic [31:0] RD1;
  logic [31:0] RD2;
  logic [4:0]  WA_W;
  logic [31:0] WD_W;
  logic        WE_W;
  logic [31:0] wb_count;

  modport master (
    output IR_W, PC_W, ALUout_W, DMout_W, Wreg_sel, Wdata_sel, GRF_WE, A1, A2,
    input  RD1, RD2, WA_W, WD_W, WE_W, wb_count
  );

  modport slave (
    input  IR_W, PC_W, ALUout_W, DMout_W, Wreg_sel, Wdata_sel, GRF_WE, A1, A2,
    output RD1, RD2, WA_W, WD_W, WE_W, wb_count
  );
endinterface

// File: rtl/wb_grf.sv
// 32x32 general register file with writeback destination/data select and a
// committed-write counter. Define GRF_BYPASS_EN for same-cycle write-to-read bypass.
module wb_grf (
  input  logic     clk,
  input  logic     reset,
  wb_grf_if.slave  bus
);

  logic [31:0] regs_q [32];
  logic [31:0] regs_d [32];
  logic [31:0] wb_count_q;
  logic [31:0] wb_count_d;

  logic [4:0]  wa;
  logic [31:0] wd;
  logic        we;
  logic [31:0] rd1;
  logic [31:0] rd2;

  // Only the rt/rd fields of the instruction matter here.
  logic unused_ir;
  assign unused_ir = ^{bus.IR_W[31:21], bus.IR_W[10:0]};

  always_comb begin
    wa = 5'd0;
    case (bus.Wreg_sel)
      2'd0:    wa = bus.IR_W[20:16];
      2'd1:    wa = bus.IR_W[15:11];
      2'd2:    wa = 5'd31;
      default: wa = 5'd0;
    endcase
  end

  always_comb begin
    wd = 32'h0;
    case (bus.Wdata_sel)
      2'd0:    wd = bus.ALUout_W;
      2'd1:    wd = bus.DMout_W;
      2'd2:    wd = bus.PC_W + 32'd8;
      default: wd = 32'h0;
    endcase
  end

  assign we = bus.GRF_WE && (wa != 5'd0);

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      regs_d[i] = regs_q[i];
    end
    wb_count_d = wb_count_q;
    if (we) begin
      regs_d[wa] = wd;
      wb_count_d = wb_count_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= 32'h0;
      end
      wb_count_q <= 32'h0;
    end else begin
      for (int i = 0; i < 32; i++) begin
        regs_q[i] <= regs_d[i];
      end
      wb_count_q <= wb_count_d;
    end
  end

  always_comb begin
    rd1 = (bus.A1 == 5'd0) ? 32'h0 : regs_q[bus.A1];
    rd2 = (bus.A2 == 5'd0) ? 32'h0 : regs_q[bus.A2];
`ifdef GRF_BYPASS_EN
    // we already implies wa != 0, so $0 can never be bypassed.
    if (we && !reset && (bus.A1 == wa)) begin
      rd1 = wd;
    end
    if (we && !reset && (bus.A2 == wa)) begin
      rd2 = wd;
    end
`else
    // No bypass: the hazard unit forwards from WD_W during the write cycle.
`endif
  end

  assign bus.RD1      = rd1;
  assign bus.RD2      = rd2;
  assign bus.WA_W     = wa;
  assign bus.WD_W     = wd;
  assign bus.WE_W     = we;
  assign bus.wb_count = wb_count_q;

endmodule

// File: tb/tb_wb_grf.sv
// Bench for wb_grf: directed vector table, counter-wrap sequence, then
// randomized cycles against an array-based register file model.
module tb_wb_grf;

  logic clk;
  logic reset;
  wb_grf_if bus ();

  wb_grf dut (.clk(clk), .reset(reset), .bus(bus));

  initial clk = 1'b0;
  always #5 clk = ~clk;

`ifdef GRF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        rst;
    logic [31:0] ir;
    logic [31:0] pc;
    logic [31:0] alu;
    logic [31:0] dm;
    logic [1:0]  ws;
    logic [1:0]  ds;
    logic        we;
    logic [4:0]  a1;
    logic [4:0]  a2;
    logic [4:0]  e_wa;
    logic [31:0] e_wd;
    logic        e_we;
    logic [31:0] e_rd1;
    logic [31:0] e_rd2;
    logic [31:0] e_cnt;
  } vec_t;

  localparam int NV = 16;
  vec_t tbl [NV];

  task automatic drive(input logic rst, input logic [31:0] ir, input logic [31:0] pc,
                       input logic [31:0] alu, input logic [31:0] dm, input logic [1:0] ws,
                       input logic [1:0] ds, input logic we, input logic [4:0] a1,
                       input logic [4:0] a2);
    reset         = rst;
    bus.IR_W      = ir;
    bus.PC_W      = pc;
    bus.ALUout_W  = alu;
    bus.DMout_W   = dm;
    bus.Wreg_sel  = ws;
    bus.Wdata_sel = ds;
    bus.GRF_WE    = we;
    bus.A1        = a1;
    bus.A2        = a2;
  endtask

  logic [31:0] m_regs [32];
  logic [31:0] m_cnt;

  initial begin
    logic [31:0] ir, pc, alu, dm, e_wd, e_rd1, e_rd2;
    logic [1:0]  ws, ds;
    logic        we, rst, e_we;
    logic [4:0]  a1, a2, e_wa;

    //            rst ir            pc            alu           dm            ws ds we a1 a2  wa  wd            we rd1                             rd2           cnt
    tbl[0]  = '{1, 32'h0,        32'h0,        32'h0,        32'h0,        0, 0, 0, 0, 0,  0,  32'h0,        0, 32'h0,                          32'h0,        0};
    tbl[1]  = '{0, 32'h0000_2800, 32'h0,       32'h1234_5678, 32'h0,       1, 0, 1, 5, 0,  5,  32'h1234_5678, 1, BYP ? 32'h1234_5678 : 32'h0,  32'h0,        1};
    tbl[2]  = '{0, 32'h0,        32'h0,        32'h0,        32'h0,        3, 3, 0, 5, 0,  0,  32'h0,        0, 32'h1234_5678,                  32'h0,        1};
    tbl[3]  = '{0, 32'h0,        32'h0000_3000, 32'h0,       32'h0,        2, 2, 1, 31, 5, 31, 32'h0000_3008, 1, BYP ? 32'h3008 : 32'h0,        32'h1234_5678, 2};
    tbl[4]  = '{0, 32'h0,        32'hFFFF_FFFC, 32'h0,       32'h0,        2, 2, 1, 31, 5, 31, 32'h0000_0004, 1, BYP ? 32'h4 : 32'h3008,        32'h1234_5678, 3};
    tbl[5]  = '{0, 32'h0,        32'h0,        32'hDEAD_BEEF, 32'h0,       0, 0, 1, 0, 31, 0,  32'hDEAD_BEEF, 0, 32'h0,                          32'h4,        3};
    tbl[6]  = '{0, 32'h0,        32'h0,        32'h1,        32'h0,        3, 0, 1, 31, 31, 0, 32'h1,        0, 32'h4,                          32'h4,        3};
    tbl[7]  = '{0, 32'h0008_0000, 32'h0,       32'h0,        32'hCAFE_0001, 0, 1, 1, 8, 8, 8,  32'hCAFE_0001, 1, BYP ? 32'hCAFE_0001 : 32'h0,  BYP ? 32'hCAFE_0001 : 32'h0, 4};
    tbl[8]  = '{0, 32'h0,        32'h0,        32'h0,        32'h0,        3, 3, 0, 8, 8,  0,  32'h0,        0, 32'hCAFE_0001,                  32'hCAFE_0001, 4};
    tbl[9]  = '{0, 32'h0000_1800, 32'h0,       32'h55,       32'h0,        1, 0, 1, 3, 8,  3,  32'h55,       1, BYP ? 32'h55 : 32'h0,           32'hCAFE_0001, 5};
    tbl[10] = '{1, 32'h0000_2000, 32'h0,       32'h66,       32'h0,        1, 0, 1, 3, 4,  4,  32'h66,       1, 32'h55,                         32'h0,        0};
    tbl[11] = '{0, 32'h0,        32'h0,        32'h0,        32'h0,        3, 3, 0, 3, 4,  0,  32'h0,        0, 32'h0,                          32'h0,        0};
    tbl[12] = '{0, 32'h0000_2000, 32'h0,       32'h66,       32'h0,        1, 0, 1, 4, 3,  4,  32'h66,       1, BYP ? 32'h66 : 32'h0,           32'h0,        1};
    tbl[13] = '{0, 32'h0,        32'h0,        32'h0,        32'h0,        3, 3, 0, 4, 3,  0,  32'h0,        0, 32'h66,                         32'h0,        1};
    tbl[14] = '{0, 32'h0000_4800, 32'h0,       32'h0000_FFFF, 32'h0,       1, 3, 1, 9, 4,  9,  32'h0,        1, 32'h0,                          32'h66,       2};
    tbl[15] = '{0, 32'h0,        32'h0,        32'h0,        32'h0,        3, 3, 0, 9, 0,  0,  32'h0,        0, 32'h0,                          32'h0,        2};

    // Initial reset edge so the register contents are defined before checking.
    drive(1, 0, 0, 0, 0, 2'd3, 2'd3, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < NV; i++) begin
      drive(tbl[i].rst, tbl[i].ir, tbl[i].pc, tbl[i].alu, tbl[i].dm,
            tbl[i].ws, tbl[i].ds, tbl[i].we, tbl[i].a1, tbl[i].a2);
      #1;
      chk($sformatf("v%0d_wa", i),  {27'h0, bus.WA_W}, {27'h0, tbl[i].e_wa});
      chk($sformatf("v%0d_wd", i),  bus.WD_W, tbl[i].e_wd);
      chk($sformatf("v%0d_we", i),  {31'h0, bus.WE_W}, {31'h0, tbl[i].e_we});
      chk($sformatf("v%0d_rd1", i), bus.RD1, tbl[i].e_rd1);
      chk($sformatf("v%0d_rd2", i), bus.RD2, tbl[i].e_rd2);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_cnt", i), bus.wb_count, tbl[i].e_cnt);
      @(negedge clk);
    end

    // Counter wrap: preload the count, then one more committed write.
    drive(0, 0, 0, 0, 0, 2'd3, 2'd3, 0, 10, 0);
    force dut.wb_count_q = 32'hFFFF_FFFF;
    #1;
    release dut.wb_count_q;
    @(posedge clk);
    #1;
    chk("wrap_preload", bus.wb_count, 32'hFFFF_FFFF);
    @(negedge clk);
    drive(0, 32'h0000_5000, 0, 32'hA5A5_0010, 0, 2'd1, 2'd0, 1, 10, 0);
    @(posedge clk);
    #1;
    chk("wrap_zero", bus.wb_count, 32'h0);
    @(negedge clk);
    drive(0, 0, 0, 0, 0, 2'd3, 2'd3, 0, 10, 0);
    #1;
    chk("wrap_reg10", bus.RD1, 32'hA5A5_0010);

    // Randomized phase against the model, starting from a clean reset.
    @(negedge clk);
    drive(1, 0, 0, 0, 0, 2'd3, 2'd3, 0, 0, 0);
    @(posedge clk);
    @(negedge clk);
    for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
    m_cnt = 32'h0;

    for (int n = 0; n < 2000; n++) begin
      ir = $urandom;
      ir[20:16] = 5'($urandom_range(0, 7));
      ir[15:11] = 5'($urandom_range(0, 7));
      pc  = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
      alu = $urandom;
      dm  = $urandom;
      ws  = 2'($urandom_range(0, 3));
      ds  = 2'($urandom_range(0, 3));
      we  = ($urandom_range(0, 3) != 0);
      a1  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      a2  = ($urandom_range(0, 9) == 0) ? 5'd31 : 5'($urandom_range(0, 7));
      rst = ($urandom_range(0, 63) == 0);
      drive(rst, ir, pc, alu, dm, ws, ds, we, a1, a2);

      e_wa = (ws == 2'd0) ? ir[20:16] : (ws == 2'd1) ? ir[15:11] : (ws == 2'd2) ? 5'd31 : 5'd0;
      e_wd = (ds == 2'd0) ? alu : (ds == 2'd1) ? dm : (ds == 2'd2) ? pc + 32'd8 : 32'h0;
      e_we = we && (e_wa != 5'd0);
      e_rd1 = (a1 == 5'd0) ? 32'h0 : m_regs[a1];
      e_rd2 = (a2 == 5'd0) ? 32'h0 : m_regs[a2];
      if (BYP && e_we && !rst && (a1 == e_wa)) e_rd1 = e_wd;
      if (BYP && e_we && !rst && (a2 == e_wa)) e_rd2 = e_wd;

      #1;
      chk("rnd_wa",  {27'h0, bus.WA_W}, {27'h0, e_wa});
      chk("rnd_wd",  bus.WD_W, e_wd);
      chk("rnd_we",  {31'h0, bus.WE_W}, {31'h0, e_we});
      chk("rnd_rd1", bus.RD1, e_rd1);
      chk("rnd_rd2", bus.RD2, e_rd2);
      @(posedge clk);
      if (rst) begin
        for (int r = 0; r < 32; r++) m_regs[r] = 32'h0;
        m_cnt = 32'h0;
      end else if (e_we) begin
        m_regs[e_wa] = e_wd;
        m_cnt = m_cnt + 32'd1;
      end
      #1;
      chk("rnd_cnt", bus.wb_count, m_cnt);
      @(negedge clk);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
